// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake, 2-entry skid buffer, flush.
// Optional stall/bubble perf counters are built when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_pipe_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 5,
    parameter int CTRL_W   = 8,
    parameter int RD_W     = 5
`ifdef EX_MEM_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
`endif
);

    localparam int PW = NUM_DATA * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic [PW-1:0]     skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_fire_s  = in_valid & in_ready_q;
    assign out_fire_s = out_valid_q & out_ready;

    // Next-state and storage update; main_ctrl is zeroed whenever the stage empties
    // so the registered out_ctrl never shows stale control on a bubble.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                        state_d     = ST_ONE;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end else if (in_fire_s) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_rd_d   = in_rd;
                        state_d     = ST_TWO;
                    end else if (out_fire_s) begin
                        main_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end else begin
                        state_d     = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_rd_d   = skid_rd_q;
                        state_d     = ST_ONE;
                    end else begin
                        state_d     = ST_TWO;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    state_d     = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_rd    = main_rd_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush does not touch them.
    always_comb begin
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage; counter checks build only with EX_MEM_PERF_CNT_EN.
module tb_ex_mem_pipe_stage;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [159:0] in_data, out_data;
    logic [7:0]   in_ctrl, out_ctrl;
    logic [4:0]   in_rd, out_rd;
    int           n_vec = 0;
    int           n_err = 0;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0]  stall_cnt, bubble_cnt;
    logic         v4_in_valid, v4_in_ready, v4_out_valid, v4_out_ready;
    logic [159:0] v4_out_data;
    logic [7:0]   v4_out_ctrl;
    logic [4:0]   v4_out_rd;
    logic [3:0]   v4_stall, v4_bubble;
`endif

    always #5 clk = ~clk;

    ex_mem_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_rd(out_rd)
`ifdef EX_MEM_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

`ifdef EX_MEM_PERF_CNT_EN
    ex_mem_pipe_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .in_data(160'h0), .in_ctrl(8'h81), .in_rd(5'd1),
        .out_valid(v4_out_valid), .out_ready(v4_out_ready),
        .out_data(v4_out_data), .out_ctrl(v4_out_ctrl), .out_rd(v4_out_rd),
        .stall_cnt(v4_stall), .bubble_cnt(v4_bubble)
    );
`endif

    // Word 1 carries the ALU value; word 0 gets a derived branch target.
    function automatic logic [159:0] pk(input logic [31:0] a);
        return {32'h0, 32'h0, 32'h0, a, a + 32'h0000_1000};
    endfunction

    function automatic logic [7:0] ct(input logic [31:0] a);
        return 8'h80 | a[7:0];
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [4:0] r);
        in_valid = 1'b1;
        in_data  = pk(a);
        in_ctrl  = ct(a);
        in_rd    = r;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
        in_ctrl  = 8'h0;
        in_rd    = 5'd0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [4:0] r);
        chk({tag, "_valid"}, {191'h0, out_valid}, 192'h1);
        chk({tag, "_data"}, {32'h0, out_data}, {32'h0, pk(a)});
        chk({tag, "_ctrl"}, {184'h0, out_ctrl}, {184'h0, ct(a)});
        chk({tag, "_rd"}, {187'h0, out_rd}, {187'h0, r});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
`ifdef EX_MEM_PERF_CNT_EN
        v4_in_valid = 1'b0; v4_out_ready = 1'b1;
`endif
        // 1. reset with a valid entry offered
        send(32'h0000_0010, 5'd5);
        tick(); tick();
        chk("rst_valid", {191'h0, out_valid}, 192'h0);
        chk("rst_ctrl", {184'h0, out_ctrl}, 192'h0);
        chk("rst_ready", {191'h0, in_ready}, 192'h1);
        chk("rst_data", {32'h0, out_data}, 192'h0);
        chk("rst_rd", {187'h0, out_rd}, 192'h0);
        rst_n = 1'b1;
        tick();
        chk_head("first", 32'h0000_0010, 5'd5);
        idle();
        tick();
        chk("first_gone", {191'h0, out_valid}, 192'h0);
        chk("bubble_ctrl", {184'h0, out_ctrl}, 192'h0);

        // 2. back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 5'(i));
            tick();
            chk_head("stream", 32'(i), 5'(i));
            chk("stream_ready", {191'h0, in_ready}, 192'h1);
        end
        idle();
        tick();
        chk("stream_end", {191'h0, out_valid}, 192'h0);

        // 3. back-pressure A,B,C
        out_ready = 1'b0;
        send(32'h0000_00A0, 5'd10);
        tick();
        chk_head("bp_a0", 32'h0000_00A0, 5'd10);
        send(32'h0000_00B0, 5'd11);
        tick();
        chk_head("bp_a1", 32'h0000_00A0, 5'd10);
        chk("bp_full", {191'h0, in_ready}, 192'h0);
        send(32'h0000_00C0, 5'd12);
        tick();
        chk_head("bp_a2", 32'h0000_00A0, 5'd10);
        chk("bp_full2", {191'h0, in_ready}, 192'h0);
        out_ready = 1'b1;
        tick();
        chk_head("bp_b", 32'h0000_00B0, 5'd11);
        chk("bp_ready", {191'h0, in_ready}, 192'h1);
        tick();
        chk_head("bp_c", 32'h0000_00C0, 5'd12);
        idle();
        tick();
        chk("bp_end", {191'h0, out_valid}, 192'h0);

        // 4. flush while two entries are held and D is offered
        out_ready = 1'b0;
        send(32'h0000_00E0, 5'd14);
        tick();
        send(32'h0000_00F0, 5'd15);
        tick();
        chk("fl_two", {191'h0, in_ready}, 192'h0);
        send(32'h0000_00D0, 5'd13);
        flush = 1'b1;
        tick();
        chk("fl_valid", {191'h0, out_valid}, 192'h0);
        chk("fl_ctrl", {184'h0, out_ctrl}, 192'h0);
        chk("fl_ready", {191'h0, in_ready}, 192'h1);
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        tick();
        chk("fl_no_d", {191'h0, out_valid}, 192'h0);
        tick();
        chk("fl_no_d2", {191'h0, out_valid}, 192'h0);

        // 5. simultaneous in/out fire in ONE
        send(32'h0000_0020, 5'd20);
        tick();
        chk_head("sim0", 32'h0000_0020, 5'd20);
        for (int k = 1; k <= 4; k++) begin
            send(32'h0000_0020 + 32'(k), 5'(20 + k));
            tick();
            chk_head("sim", 32'h0000_0020 + 32'(k), 5'(20 + k));
            chk("sim_ready", {191'h0, in_ready}, 192'h1);
        end
        idle();
        tick();
        chk("sim_end", {191'h0, out_valid}, 192'h0);

`ifdef EX_MEM_PERF_CNT_EN
        // 6. counters: 3 bubbles (incl. load cycle) then 3 stalls; CNT_W=4 saturation
        rst_n = 1'b0;
        v4_in_valid = 1'b1; v4_out_ready = 1'b0;
        tick();
        chk("cnt_rst_s", {160'h0, stall_cnt}, 192'h0);
        chk("cnt_rst_b", {160'h0, bubble_cnt}, 192'h0);
        rst_n = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        send(32'h0000_0030, 5'd3);
        tick();
        idle();
        tick(); tick(); tick();
        chk("cnt_stall", {160'h0, stall_cnt}, 192'd3);
        chk("cnt_bubble", {160'h0, bubble_cnt}, 192'd3);
        out_ready = 1'b1;
        tick();
        chk("cnt_stall_hold", {160'h0, stall_cnt}, 192'd3);
        for (int j = 0; j < 20; j++) tick();
        chk("cnt4_sat", {188'h0, v4_stall}, 192'd15);
        chk("cnt4_bub", {188'h0, v4_bubble}, 192'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
